// File: rtl/loop_player.sv
`default_nettype none
// ============================================================================
//  Module      : loop_player
//  Description : Multi-channel sample buffer with a programmable playback
//                window, one-shot or loop mode, and a rate divider.
//                The host writes samples into per-lane memories. The player
//                walks addresses start_addr..end_addr (wrapping past the top
//                of memory if needed) and emits one sample per divided tick.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            clock
//    reset          synchronous, active-high reset
//    buf_write      write strobe
//    buf_wmask      per-lane write enable for this strobe
//    buf_address    write address
//    buf_writedata  sample written to every masked lane
//    start          pulse, begins playback (accepted only when idle)
//    stop           pulse, aborts playback
//    loop_en        1 = repeat window forever, 0 = play it once
//    start_addr     first address of the window
//    end_addr       last address of the window (inclusive)
//    divider        tick period is divider+1 cycles
//    out_data       lane i at [DATA_W*i +: DATA_W]
//    out_valid      1-cycle pulse, out_data updated
//    busy           high while a playback is in progress
//    done           sticky, one-shot completed; cleared by an accepted start
//    done_pulse     1-cycle pulse with the final one-shot out_valid
//    loop_count     completed window wraps, saturating
// ============================================================================
module loop_player #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 1,
    parameter int ADDR_W   = 10,
    parameter int DIV_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         buf_write,
    input  logic [CHANNELS-1:0]          buf_wmask,
    input  logic [ADDR_W-1:0]            buf_address,
    input  logic [DATA_W-1:0]            buf_writedata,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop_en,
    input  logic [ADDR_W-1:0]            start_addr,
    input  logic [ADDR_W-1:0]            end_addr,
    input  logic [DIV_W-1:0]             divider,
    output logic [DATA_W*CHANNELS-1:0]   out_data,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         done_pulse,
    output logic [15:0]                  loop_count
);

    localparam int c_DEPTH = 1 << ADDR_W;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_PLAY = 2'd1;
    localparam logic [1:0] c_LAST = 2'd2;

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0]  c_DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]       c_LC_MAX   = 16'hFFFF;

    logic [1:0]                  r_state;
    logic [ADDR_W-1:0]           r_cur;
    logic [DIV_W-1:0]            r_div_cnt;
    logic [ADDR_W-1:0]           r_start_l;
    logic [ADDR_W-1:0]           r_end_l;
    logic                        r_loop_l;
    logic [DIV_W-1:0]            r_divider_l;
    logic                        r_rd_pending;
    logic [DATA_W*CHANNELS-1:0]  r_out_data;
    logic                        r_out_valid;
    logic                        r_done;
    logic                        r_done_pulse;
    logic [15:0]                 r_loop_count;

    logic                        w_tick;
    logic                        w_at_end;
    logic [DATA_W*CHANNELS-1:0]  w_rd_data;

    // A tick fires on the first cycle of each divider period. A same-cycle
    // stop wins, so no read is issued on the way back to idle.
    assign w_tick   = (r_state == c_PLAY) && (r_div_cnt == '0) && !stop;
    assign w_at_end = (r_cur == r_end_l);

    // ------------------------------------------------------------------------
    // Lane memories. The read register samples the array before this edge's
    // write lands, so a write to the address being read returns old data.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic [DATA_W-1:0] r_mem [c_DEPTH];
            logic [DATA_W-1:0] r_lane_q;

            always_ff @(posedge clk) begin
                if (buf_write && buf_wmask[gi]) begin
                    r_mem[buf_address] <= buf_writedata;
                end
                if (w_tick) begin
                    r_lane_q <= r_mem[r_cur];
                end
            end

            assign w_rd_data[DATA_W*gi +: DATA_W] = r_lane_q;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Playback control and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_cur        <= '0;
            r_div_cnt    <= '0;
            r_start_l    <= '0;
            r_end_l      <= '0;
            r_loop_l     <= 1'b0;
            r_divider_l  <= '0;
            r_rd_pending <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
            r_loop_count <= '0;
        end else begin
            // Second pipeline stage: a read issued last cycle is presented
            // now, even if playback was stopped in between.
            r_rd_pending <= w_tick;
            r_out_valid  <= r_rd_pending;
            if (r_rd_pending) begin
                r_out_data <= w_rd_data;
            end
            r_done_pulse <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_start_l    <= start_addr;
                        r_end_l      <= end_addr;
                        r_loop_l     <= loop_en;
                        r_divider_l  <= divider;
                        r_cur        <= start_addr;
                        r_div_cnt    <= '0;
                        r_done       <= 1'b0;
                        r_loop_count <= '0;
                        r_state      <= c_PLAY;
                    end
                end

                c_PLAY: begin
                    if (stop) begin
                        r_state <= c_IDLE;
                    end else begin
                        if (r_div_cnt == r_divider_l) begin
                            r_div_cnt <= '0;
                        end else begin
                            r_div_cnt <= r_div_cnt + c_DIV_ONE;
                        end

                        if (w_tick) begin
                            if (w_at_end) begin
                                if (r_loop_l) begin
                                    r_cur <= r_start_l;
                                    if (r_loop_count != c_LC_MAX) begin
                                        r_loop_count <= r_loop_count + 16'd1;
                                    end
                                end else begin
                                    r_state <= c_LAST;
                                end
                            end else begin
                                // Natural wrap past the top of memory.
                                r_cur <= r_cur + c_ADDR_ONE;
                            end
                        end
                    end
                end

                c_LAST: begin
                    // The final read is in flight; it surfaces this edge
                    // together with the completion pulse.
                    r_done_pulse <= 1'b1;
                    r_done       <= 1'b1;
                    r_state      <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign busy       = (r_state != c_IDLE);
    assign done       = r_done;
    assign done_pulse = r_done_pulse;
    assign loop_count = r_loop_count;

endmodule
`default_nettype wire

// File: tb/tb_loop_player.sv
`default_nettype none
// ============================================================================
//  Module      : tb_loop_player
//  Description : Self-checking bench for loop_player (2 lanes, 16-deep).
//                A behavioural model tracks memory contents and playback
//                position arithmetically; every cycle the DUT outputs are
//                compared against it. Directed scenarios add literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_loop_player;

    localparam int DW   = 32;
    localparam int CH   = 2;
    localparam int AW   = 4;
    localparam int DIVW = 16;
    localparam int DEPTH = 16;

    logic                clk;
    logic                reset;
    logic                buf_write;
    logic [CH-1:0]       buf_wmask;
    logic [AW-1:0]       buf_address;
    logic [DW-1:0]       buf_writedata;
    logic                start;
    logic                stop;
    logic                loop_en;
    logic [AW-1:0]       start_addr;
    logic [AW-1:0]       end_addr;
    logic [DIVW-1:0]     divider;
    logic [DW*CH-1:0]    out_data;
    logic                out_valid;
    logic                busy;
    logic                done;
    logic                done_pulse;
    logic [15:0]         loop_count;

    loop_player #(
        .DATA_W   (DW),
        .CHANNELS (CH),
        .ADDR_W   (AW),
        .DIV_W    (DIVW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .buf_write     (buf_write),
        .buf_wmask     (buf_wmask),
        .buf_address   (buf_address),
        .buf_writedata (buf_writedata),
        .start         (start),
        .stop          (stop),
        .loop_en       (loop_en),
        .start_addr    (start_addr),
        .end_addr      (end_addr),
        .divider       (divider),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .busy          (busy),
        .done          (done),
        .done_pulse    (done_pulse),
        .loop_count    (loop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: playback described by elapsed cycles since start and
    // number of samples emitted; window position is n mod length.
    // ------------------------------------------------------------------------
    logic [DW-1:0] m_mem [CH][DEPTH];
    bit            m_active, m_fin, m_loop, m_pend_v, m_pend_last;
    int            m_start, m_len, m_div, m_elapsed, m_n, m_a;
    logic [63:0]   m_pend_data;
    logic [63:0]   e_data;
    bit            e_valid, e_done, e_dpulse;
    logic [15:0]   e_lc;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0; m_fin = 0; m_pend_v = 0; m_pend_last = 0;
            e_data = '0; e_valid = 0; e_done = 0; e_dpulse = 0; e_lc = '0;
        end else begin
            e_valid  = m_pend_v;
            e_dpulse = m_pend_v && m_pend_last;
            if (m_pend_v) e_data = m_pend_data;
            if (e_dpulse) e_done = 1;
            m_pend_v = 0;
            m_pend_last = 0;
            if (!m_active) begin
                if (start) begin
                    m_active  = 1;
                    m_fin     = 0;
                    m_start   = int'(start_addr);
                    m_len     = ((int'(end_addr) - int'(start_addr) + DEPTH) % DEPTH) + 1;
                    m_loop    = loop_en;
                    m_div     = int'(divider);
                    m_elapsed = 0;
                    m_n       = 0;
                    e_done    = 0;
                    e_lc      = '0;
                end
            end else if (m_fin) begin
                m_active = 0;
                m_fin    = 0;
            end else if (stop) begin
                m_active = 0;
            end else begin
                if (m_elapsed % (m_div + 1) == 0) begin
                    m_a = (m_start + (m_n % m_len)) % DEPTH;
                    m_pend_data = {m_mem[1][m_a], m_mem[0][m_a]};
                    m_pend_v = 1;
                    m_n++;
                    if (m_n % m_len == 0) begin
                        if (m_loop) begin
                            if (e_lc != 16'hFFFF) e_lc = e_lc + 16'd1;
                        end else begin
                            m_pend_last = 1;
                            m_fin = 1;
                        end
                    end
                end
                m_elapsed++;
            end
        end
        // Memory is never cleared; writes apply after this edge's read.
        if (buf_write) begin
            for (int l = 0; l < CH; l++) begin
                if (buf_wmask[l]) m_mem[l][buf_address] = buf_writedata;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",       {63'd0, busy},       {63'd0, m_active});
            chk("out_valid",  {63'd0, out_valid},  {63'd0, e_valid});
            chk("done",       {63'd0, done},       {63'd0, e_done});
            chk("done_pulse", {63'd0, done_pulse}, {63'd0, e_dpulse});
            chk("loop_count", {48'd0, loop_count}, {48'd0, e_lc});
            chk("out_data",   out_data,            e_data);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers; all input changes happen at the falling edge.
    // ------------------------------------------------------------------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wr(input logic [CH-1:0] mask, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        buf_write = 1; buf_wmask = mask; buf_address = addr; buf_writedata = data;
        @(negedge clk);
        buf_write = 0; buf_wmask = '0;
    endtask

    // Returns at the sample point right after the accepting edge (+0).
    task automatic do_start(input int s, input int e, input bit lp, input int dv);
        start = 1; start_addr = AW'(s); end_addr = AW'(e); loop_en = lp; divider = DIVW'(dv);
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        reset = 1; buf_write = 0; buf_wmask = '0; buf_address = '0; buf_writedata = '0;
        start = 0; stop = 0; loop_en = 0; start_addr = '0; end_addr = '0; divider = '0;
        step(3);
        chk_en = 1;
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_loop_count", {48'd0, loop_count}, 64'd0);
        reset = 0;

        for (int a = 0; a < DEPTH; a++) begin
            wr(2'b01, AW'(a), 32'h100 + a);
            wr(2'b10, AW'(a), 32'h200 + a);
        end

        // One-shot 0..3, back-to-back
        do_start(0, 3, 0, 0);
        step(1);
        chk("t1_no_valid_p1", {63'd0, out_valid}, 64'd0);
        step(1);
        chk("t1_first", {63'd0, out_valid, out_data[31:0]}, {31'd0, 1'b1, 32'h100});
        step(3);
        chk("t1_last", {62'd0, out_valid, done_pulse, out_data[31:0]}, {30'd0, 2'b11, 32'h103});
        chk("t1_lane1_last", {32'd0, out_data[63:32]}, 64'h203);
        chk("t1_done_busy", {62'd0, done, busy}, 64'd2);
        step(2);

        // One-shot 0..3, divider 2
        do_start(0, 3, 0, 2);
        step(2);
        chk("t2_first", {63'd0, out_valid}, 64'd1);
        step(1);
        chk("t2_gap", {63'd0, out_valid}, 64'd0);
        step(5);
        chk("t2_third", {31'd0, out_valid, out_data[31:0]}, {31'd0, 1'b1, 32'h102});
        step(3);
        chk("t2_fourth", {62'd0, out_valid, done_pulse, out_data[31:0]}, {30'd0, 2'b11, 32'h103});
        step(2);

        // Loop 2..4, then stop
        do_start(2, 4, 1, 0);
        step(4);
        chk("t3_lc1", {16'd0, loop_count, out_data[31:0]}, {32'd1, 32'h104});
        step(3);
        chk("t3_lc2", {16'd0, loop_count, out_data[31:0]}, {32'd2, 32'h104});
        stop = 1;
        step(1);
        stop = 0;
        chk("t3_stopped", {61'd0, busy, done, done_pulse}, 64'd0);
        step(3);

        // Window wrapping past the top of memory: 14,15,0,1
        do_start(14, 1, 0, 0);
        step(2);
        chk("t4_a14", {32'd0, out_data[31:0]}, 64'h10E);
        step(2);
        chk("t4_a0", {32'd0, out_data[31:0]}, 64'h100);
        step(1);
        chk("t4_a1_done", {31'd0, done_pulse, out_data[31:0]}, {31'd0, 1'b1, 32'h101});
        step(2);

        // Single-sample window with a colliding write: old data plays
        do_start(5, 5, 0, 0);
        buf_write = 1; buf_wmask = 2'b11; buf_address = 4'd5; buf_writedata = 32'hDEAD0005;
        step(1);
        buf_write = 0; buf_wmask = '0;
        step(1);
        chk("t5_old_data", out_data, {32'h205, 32'h105});
        chk("t5_done", {62'd0, done_pulse, busy}, 64'd2);
        step(2);

        // Lane masking
        wr(2'b10, 4'd0, 32'hCAFE0000);
        wr(2'b00, 4'd0, 32'h0BAD0000);
        do_start(0, 0, 0, 0);
        step(2);
        chk("t6_mask", out_data, {32'hCAFE0000, 32'h100});
        step(2);

        // Reset mid-play, then replay
        do_start(0, 15, 1, 1);
        step(5);
        reset = 1;
        step(1);
        chk("t7_rst", {out_data[61:0], out_valid, busy}, 64'd0);
        chk("t7_rst_lc_done", {47'd0, loop_count, done}, 64'd0);
        reset = 0;
        do_start(0, 15, 0, 0);
        step(20);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            buf_write     = ($urandom_range(3) == 0);
            buf_wmask     = CH'($urandom_range(3));
            buf_address   = AW'($urandom_range(DEPTH - 1));
            buf_writedata = $urandom;
            start         = ($urandom_range(7) == 0);
            start_addr    = AW'($urandom_range(DEPTH - 1));
            end_addr      = AW'($urandom_range(DEPTH - 1));
            loop_en       = ($urandom_range(2) == 0);
            divider       = DIVW'($urandom_range(3));
            stop          = ($urandom_range(39) == 0);
            reset         = ($urandom_range(499) == 0);
            step(1);
        end
        buf_write = 0; start = 0; stop = 0; reset = 0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
